fetch_sequencer: RTL and testbench

- Program-counter sequencer and 2-entry instruction buffer placed in front of the word-addressed, combinational-read InstructionMem.
- Drives the memory address, captures instruction words with their PC, and hands them to decode over a valid/ready handshake.
- Handles start, branch/jump redirect with buffer flush, halt-opcode detection and out-of-range fetch faults.

---
 rtl/fetch_sequencer.sv | 142 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-counter sequencer with a 2-entry instruction
// buffer in front of a word-addressed, combinational-read instruction memory.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               one-cycle pulse, begins fetching from RESET_PC (IDLE only)
//   imem_addr/imem_data memory address (always the PC) and same-cycle read data
//   imem_en             high in cycles where imem_data is captured
//   redirect/redirect_pc branch/jump: flush buffer, load PC, resume FETCH
//   instr_out/pc_out    buffer head entry; instr_valid = buffer non-empty
//   instr_ready         decode accepts the head entry
//   halted              high in HALT
//   fault               sticky out-of-range fetch flag, cleared by start
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] MEM_DEPTH   = 32'd64,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        imem_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic [1:0][31:0]  buf_instr_q, buf_instr_d;
    logic [1:0][31:0]  buf_pc_q, buf_pc_d;
    logic              fault_q, fault_d;

    logic pop;
    logic redirect_act;
    logic space;
    logic cap_try;
    logic in_range;
    logic cap;
    logic wr_idx;

    always_comb begin
        pop          = (count_q != 2'd0) && instr_ready;
        redirect_act = redirect && (state_q != S_IDLE);
        space        = (count_q < 2'd2) || pop;
        cap_try      = (state_q == S_FETCH) && !redirect_act && space;
        in_range     = pc_q < MEM_DEPTH;
        cap          = cap_try && in_range;
        // Tail slot. At count==2 with a pop this lands on the slot being
        // freed; at count==1 with a pop it lands on the new head.
        wr_idx       = head_q ^ count_q[0];

        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        head_d      = head_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        fault_d     = fault_q;

        if (redirect_act) begin
            // Flush wins over any pop/capture in the same cycle.
            count_d = 2'd0;
            pc_d    = redirect_pc;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FETCH;
                        pc_d    = RESET_PC;
                        fault_d = 1'b0;
                    end
                end
                S_FETCH: begin
                    if (cap_try) begin
                        if (in_range) begin
                            buf_instr_d[wr_idx] = imem_data;
                            buf_pc_d[wr_idx]    = pc_q;
                            pc_d                = pc_q + 32'd1;
                            // Halt word is still buffered and delivered.
                            if (imem_data[31:26] == HALT_OPCODE)
                                state_d = S_HALT;
                        end else begin
                            fault_d = 1'b1;
                            state_d = S_HALT;
                        end
                    end
                end
                S_HALT: ;
                default: state_d = S_IDLE;
            endcase
            if (pop)
                head_d = ~head_q;
            count_d = count_q + {1'b0, cap} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_addr   = pc_q;
    assign imem_en     = cap;
    assign instr_out   = buf_instr_q[head_q];
    assign pc_out      = buf_pc_q[head_q];
    assign instr_valid = count_q != 2'd0;
    assign halted      = state_q == S_HALT;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, ready, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] addr, data, instr, pc;
    logic        en, valid, halted, fault;
    logic [31:0] addr4, data4, instr4, pc4;
    logic        en4, valid4, halted4, fault4;

    logic [31:0] mem [0:63];
    localparam logic [31:0] HALTW = 32'hFC000006;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign data  = (addr  < 32'd64) ? mem[addr[5:0]]  : 32'h0;
    assign data4 = (addr4 < 32'd64) ? mem[addr4[5:0]] : 32'h0;

    fetch_sequencer u_dut (
        .clk(clk), .reset(rst), .start(start),
        .imem_addr(addr), .imem_data(data), .imem_en(en),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_out(instr), .pc_out(pc), .instr_valid(valid),
        .instr_ready(ready), .halted(halted), .fault(fault)
    );

    fetch_sequencer #(.MEM_DEPTH(32'd4)) u_dut4 (
        .clk(clk), .reset(rst), .start(start),
        .imem_addr(addr4), .imem_data(data4), .imem_en(en4),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_out(instr4), .pc_out(pc4), .instr_valid(valid4),
        .instr_ready(ready), .halted(halted4), .fault(fault4)
    );

    typedef struct {
        logic        rst, start, ready, redir;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc, ein;
        logic        eh, ef, een;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] w(input int i);
        return 32'h20080001 + i;
    endfunction

    task automatic add(input logic r, s, rd, rdr, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, ein,
                       input logic eh, ef, een, input logic [31:0] eaddr);
        vec_t v;
        v.rst = r; v.start = s; v.ready = rd; v.redir = rdr; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.ein = ein;
        v.eh = eh; v.ef = ef; v.een = een; v.eaddr = eaddr;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, s, rd, rdr, input logic [31:0] rp);
        @(negedge clk);
        rst = r; start = s; ready = rd; redirect = rdr; redirect_pc = rp;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = w(i);
        mem[6] = HALTW;
        rst = 1'b1; start = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Sequential fetch up to the halt word.
        add(1,0,1,0,0,  0,0,0,       0,0,0, 0);
        add(0,1,1,0,0,  0,0,0,       0,0,0, 0);
        add(0,0,1,0,0,  0,0,0,       0,0,1, 0);
        for (int k = 0; k < 6; k++)
            add(0,0,1,0,0, 1,k,w(k), 0,0,1, k+1);
        add(0,0,1,0,0,  1,6,HALTW,   1,0,0, 7);
        add(0,0,1,0,0,  0,0,0,       1,0,0, 7);
        // Backpressure, redirect flush, halt resume.
        add(1,0,0,0,0,  0,0,0,       0,0,0, 0);
        add(0,0,0,1,9,  0,0,0,       0,0,0, 0);   // redirect in IDLE ignored
        add(0,1,0,0,0,  0,0,0,       0,0,0, 0);
        add(0,0,0,0,0,  0,0,0,       0,0,1, 0);
        add(0,0,0,0,0,  1,0,w(0),    0,0,1, 1);
        add(0,0,0,0,0,  1,0,w(0),    0,0,0, 2);
        add(0,0,0,0,0,  1,0,w(0),    0,0,0, 2);
        add(0,0,0,0,0,  1,0,w(0),    0,0,0, 2);
        add(0,0,1,0,0,  1,0,w(0),    0,0,1, 2);
        add(0,0,1,0,0,  1,1,w(1),    0,0,1, 3);
        add(0,0,1,0,0,  1,2,w(2),    0,0,1, 4);
        add(0,0,1,1,10, 1,3,w(3),    0,0,0, 5);   // flush pc 3,4
        add(0,0,1,0,0,  0,0,0,       0,0,1, 10);
        add(0,0,1,0,0,  1,10,w(10),  0,0,1, 11);
        add(0,0,1,1,5,  1,11,w(11),  0,0,0, 12);
        add(0,0,1,0,0,  0,0,0,       0,0,1, 5);
        add(0,0,1,0,0,  1,5,w(5),    0,0,1, 6);
        add(0,0,1,0,0,  1,6,HALTW,   1,0,0, 7);
        add(0,0,1,0,0,  0,0,0,       1,0,0, 7);
        add(0,0,1,1,2,  0,0,0,       1,0,0, 7);   // resume from HALT
        add(0,0,1,0,0,  0,0,0,       0,0,1, 2);
        add(0,0,1,0,0,  1,2,w(2),    0,0,1, 3);
        add(0,1,1,0,0,  1,3,w(3),    0,0,1, 4);   // start ignored in FETCH
        add(0,0,1,0,0,  1,4,w(4),    0,0,1, 5);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].start, vq[i].ready, vq[i].redir, vq[i].rpc);
            chk($sformatf("v%0d valid", i),  {31'b0, valid},  {31'b0, vq[i].ev});
            chk($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vq[i].eh});
            chk($sformatf("v%0d fault", i),  {31'b0, fault},  {31'b0, vq[i].ef});
            chk($sformatf("v%0d imem_en", i),{31'b0, en},     {31'b0, vq[i].een});
            chk($sformatf("v%0d addr", i),   addr,            vq[i].eaddr);
            if (vq[i].ev) begin
                chk($sformatf("v%0d pc_out", i),    pc,    vq[i].epc);
                chk($sformatf("v%0d instr_out", i), instr, vq[i].ein);
            end
            if (vq[i].rst) begin
                chk($sformatf("v%0d rst pc_out", i),    pc,    32'h0);
                chk($sformatf("v%0d rst instr_out", i), instr, 32'h0);
            end
        end

        // Out-of-range fault on the MEM_DEPTH=4 instance.
        step(1,0,1,0,0);
        step(0,1,1,0,0);
        step(0,0,1,0,0);
        chk("flt en0", {31'b0, en4}, 32'd1);
        chk("flt addr0", addr4, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(0,0,1,0,0);
            chk($sformatf("flt valid%0d", k), {31'b0, valid4}, 32'd1);
            chk($sformatf("flt pc%0d", k), pc4, k);
            chk($sformatf("flt en%0d", k), {31'b0, en4}, (k < 3) ? 32'd1 : 32'd0);
        end
        step(0,0,1,0,0);
        chk("flt fault", {31'b0, fault4}, 32'd1);
        chk("flt halted", {31'b0, halted4}, 32'd1);
        chk("flt valid", {31'b0, valid4}, 32'd0);
        chk("flt en", {31'b0, en4}, 32'd0);
        chk("flt addr hold", addr4, 32'd4);
        step(0,0,1,1,0);
        chk("flt redir en", {31'b0, en4}, 32'd0);
        step(0,0,1,0,0);
        chk("flt resume halted", {31'b0, halted4}, 32'd0);
        chk("flt resume fault", {31'b0, fault4}, 32'd1);
        chk("flt resume en", {31'b0, en4}, 32'd1);
        chk("flt resume addr", addr4, 32'd0);
        step(0,0,1,0,0);
        chk("flt resume valid", {31'b0, valid4}, 32'd1);
        chk("flt resume pc", pc4, 32'd0);
        chk("flt sticky", {31'b0, fault4}, 32'd1);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst valid", {31'b0, valid}, 32'd0);
        chk("arst en", {31'b0, en}, 32'd0);
        chk("arst addr", addr, 32'd0);
        chk("arst halted", {31'b0, halted}, 32'd0);
        chk("arst fault4", {31'b0, fault4}, 32'd0);
        chk("arst valid4", {31'b0, valid4}, 32'd0);
        step(0,0,1,0,0);
        step(0,0,1,0,0);
        chk("arst idle valid", {31'b0, valid}, 32'd0);
        chk("arst idle en", {31'b0, en}, 32'd0);
        step(0,1,1,0,0);
        step(0,0,1,0,0);
        chk("arst restart en", {31'b0, en}, 32'd1);
        step(0,0,1,0,0);
        chk("arst restart valid", {31'b0, valid}, 32'd1);
        chk("arst restart pc", pc, 32'd0);
        chk("arst restart instr", instr, w(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
